// File: rtl/doodle_sprite_renderer_if.sv
// doodle_sprite_renderer_if: scan, sprite-state, ROM and pixel-output signals of the sprite renderer
interface doodle_sprite_renderer_if #(parameter int ADDR_W = 16);
  logic              frame_start;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic              facing_left;
  logic              pixel_valid;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ADDR_W-1:0] rom_address;
  logic [7:0]        rom_data;
  logic              out_valid;
  logic              sprite_on;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  modport master (
    output frame_start, sprite_x, sprite_y, facing_left, pixel_valid, DrawX, DrawY, rom_data,
    input  rom_address, out_valid, sprite_on, red, green, blue
  );
  modport slave (
    input  frame_start, sprite_x, sprite_y, facing_left, pixel_valid, DrawX, DrawY, rom_data,
    output rom_address, out_valid, sprite_on, red, green, blue
  );
endinterface

// File: rtl/doodle_sprite_renderer.sv
// doodle_sprite_renderer: scan-to-ROM address generation, ROM latency alignment and palette lookup for the doodle sprite.
// Define SPRITE_FLIP_EN to enable horizontal mirroring via facing_left.
module doodle_sprite_renderer #(
  parameter int W      = 32,
  parameter int H      = 32,
  parameter int ADDR_W = 16
) (
  input logic Clk,
  input logic Reset,
  doodle_sprite_renderer_if.slave bus
);
  logic [9:0]  lx, ly;
  logic        hit, hit_a, valid_a, hit_b, valid_b, opaque;
  logic [10:0] x11, y11, lx11, ly11, ox, oy, col;
  logic [3:0]  idx;
  logic [23:0] rgb;
`ifdef SPRITE_FLIP_EN
  logic        lf;
`endif
  always_comb begin
    x11    = {1'b0, bus.DrawX};
    y11    = {1'b0, bus.DrawY};
    lx11   = {1'b0, lx};
    ly11   = {1'b0, ly};
    ox     = x11 - lx11;
    oy     = y11 - ly11;
    // 11-bit bounds so a sprite hanging past column 1023 never wraps onto column 0
    hit    = bus.pixel_valid && x11 >= lx11 && x11 < lx11 + 11'(W) && y11 >= ly11 && y11 < ly11 + 11'(H);
`ifdef SPRITE_FLIP_EN
    col    = lf ? 11'(W - 1) - ox : ox;
`else
    col    = ox;
`endif
    idx    = bus.rom_data[3:0];
    opaque = hit_b && idx != 4'd0;
    rgb    = idx == 4'd1 ? 24'h000000 :
             idx == 4'd2 ? 24'hD2E063 :
             idx == 4'd3 ? 24'h8FA83A :
             idx == 4'd4 ? 24'hFFFFFF :
             idx == 4'd5 ? 24'hF4C542 : 24'h808080;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lx              <= '0;
      ly              <= '0;
`ifdef SPRITE_FLIP_EN
      lf              <= 1'b0;
`endif
      bus.rom_address <= '0;
      hit_a           <= 1'b0;
      valid_a         <= 1'b0;
      hit_b           <= 1'b0;
      valid_b         <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.sprite_on   <= 1'b0;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
    end else begin
      if (bus.frame_start) begin
        lx <= bus.sprite_x;
        ly <= bus.sprite_y;
`ifdef SPRITE_FLIP_EN
        lf <= bus.facing_left;
`endif
      end
      bus.rom_address                 <= hit ? ADDR_W'(oy) * ADDR_W'(W) + ADDR_W'(col) : '0;
      hit_a                           <= hit;
      valid_a                         <= bus.pixel_valid;
      hit_b                           <= hit_a;
      valid_b                         <= valid_a;
      bus.out_valid                   <= valid_b;
      bus.sprite_on                   <= opaque;
      {bus.red, bus.green, bus.blue}  <= opaque ? rgb : 24'h0;
    end
  end
endmodule

// File: tb/tb_doodle_sprite_renderer.sv
// tb_doodle_sprite_renderer: scoreboard bench with a coordinate-level reference model of the sprite renderer
module tb_doodle_sprite_renderer;
  typedef struct { bit on; logic [23:0] rgb; } exp_t;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  doodle_sprite_renderer_if #(.ADDR_W(16)) bus ();
  doodle_sprite_renderer #(.W(32), .H(32), .ADDR_W(16)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  logic [7:0]  rom [1024];
  logic [23:0] pal [16];
  exp_t        eq [$];
  int          aq [$];
  int          checks = 0, passes = 0;
  int          mlx = 0, mly = 0;
  bit          mlf = 0;
  always @(posedge Clk) bus.rom_data <= rom[bus.rom_address[9:0]];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask
  initial forever begin
    @(posedge Clk);
    #1;
    if (aq.size() != 0) chk("rom_address", 32'(bus.rom_address), 32'(aq.pop_front()));
    if (bus.out_valid === 1'b1) begin
      if (eq.size() == 0) begin
        checks++;
        $display("FAIL out_valid_spurious: got out_valid 1 expected 0 at %0t", $time);
      end else begin
        exp_t e;
        e = eq.pop_front();
        chk("sprite_on", 32'(bus.sprite_on), 32'(e.on));
        chk("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e.rgb));
      end
    end else begin
      chk("out_valid_known", 32'(bus.out_valid), 32'd0);
      chk("bubble_sprite_on", 32'(bus.sprite_on), 32'd0);
      chk("bubble_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    end
  end
  task automatic drive(input int x, y, input bit pv, fs, input int sx, sy, input bit fl, rst);
    int addr, col;
    bit hit;
    exp_t e;
    @(negedge Clk);
    Reset = rst;
    bus.pixel_valid = pv;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.frame_start = fs;
    bus.sprite_x = 10'(sx);
    bus.sprite_y = 10'(sy);
    bus.facing_left = fl;
    if (rst) begin
      eq.delete();
      aq.push_back(0);
      mlx = 0; mly = 0; mlf = 0;
    end else begin
      x = x & 1023;
      y = y & 1023;
      hit = pv && x >= mlx && x < mlx + 32 && y >= mly && y < mly + 32;
`ifdef SPRITE_FLIP_EN
      col = mlf ? 31 - (x - mlx) : x - mlx;
`else
      col = x - mlx;
`endif
      addr = hit ? (y - mly) * 32 + col : 0;
      aq.push_back(addr);
      e.on = hit && rom[addr][3:0] != 0;
      e.rgb = e.on ? pal[rom[addr][3:0]] : 24'h0;
      if (pv) eq.push_back(e);
      if (fs) begin mlx = sx & 1023; mly = sy & 1023; mlf = fl; end
    end
  endtask
  task automatic px(input int x, y);
    drive(x, y, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic frame(input int sx, sy, input bit fl);
    drive(0, 0, 0, 1, sx, sy, fl, 0);
  endtask
  initial begin
    int sx, sy, x, y;
    bit fl;
    bus.pixel_valid = 0; bus.frame_start = 0; bus.DrawX = 0; bus.DrawY = 0;
    bus.sprite_x = 0; bus.sprite_y = 0; bus.facing_left = 0;
    for (int i = 0; i < 16; i++) pal[i] = 24'h808080;
    pal[0] = 24'h0; pal[1] = 24'h000000; pal[2] = 24'hD2E063;
    pal[3] = 24'h8FA83A; pal[4] = 24'hFFFFFF; pal[5] = 24'hF4C542;
    for (int i = 0; i < 1024; i++) rom[i] = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
    rom[0] = 8'h12; rom[1023] = 8'h02; rom[191] = 8'h00; rom[160] = 8'h02; rom[13] = 8'h05;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    frame(100, 200, 0);
    px(100, 200); px(131, 231); px(132, 200); px(99, 200);
    frame(100, 200, 1);
    px(100, 205); px(100, 200); px(131, 231);
    drive(100, 205, 1, 0, 300, 300, 0, 0);
    px(105, 210);
    drive(110, 210, 1, 1, 110, 210, 0, 0);
    px(110, 210); px(109, 210);
    frame(1010, 40, 0);
    px(1023, 40);
    for (int i = 0; i < 10; i++) px(i, 40);
    for (int i = 0; i < 10; i++) drive(1010 + i, 41, 1, 0, 0, 0, 0, i == 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    frame(0, 0, 1);
    px(0, 0); px(31, 31); px(32, 0);
    sx = 200; sy = 100; fl = 0;
    frame(sx, sy, fl);
    for (int i = 0; i < 2000; i++) begin
      bit fs, rst;
      fs = ($urandom % 60 == 0);
      rst = ($urandom % 400 == 0);
      if (fs) begin
        sx = ($urandom % 4 == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 1023);
        sy = $urandom_range(0, 500);
        fl = 1'($urandom);
      end
      x = ($urandom % 5 == 0) ? $urandom_range(0, 1023) : (mlx + $urandom_range(0, 45) - 6) & 1023;
      y = ($urandom % 5 == 0) ? $urandom_range(0, 1023) : (mly + $urandom_range(0, 45) - 6) & 1023;
      drive(x, y, $urandom % 8 != 0, fs && !rst, fs ? sx : $urandom_range(0, 1023), sy, fl, rst);
    end
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && (eq.size() != 0 || aq.size() != 0); i++) @(posedge Clk);
    #2;
    if (eq.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pixels outstanding expected 0", eq.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
